// File: rtl/ifu_line_cache_pkg.sv
// ifu_line_cache_pkg: shared widths, line geometry and FSM encoding for the fetch line cache
package ifu_line_cache_pkg;
  localparam int PCBUS = 64;
  localparam int LINE_BYTES = 16;
  localparam int LINE_OFF_W = $clog2(LINE_BYTES);
  localparam logic [31:0] ZEROWORD = 32'h0;
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_BEAT0 = 3'd2,
    S_BEAT1 = 3'd3,
    S_FILL  = 3'd4
  } state_t;
endpackage

// File: rtl/ifu_line_align.sv
// ifu_line_align: shifts a 128-bit line so slot 0 is the word at off, zero-filling past line end
module ifu_line_align
  import ifu_line_cache_pkg::*;
(
  input  logic [127:0] line,
  input  logic [1:0]   off,
  output logic [127:0] inst,
  output logic [2:0]   cnt
);
  for (genvar k = 0; k < 4; k++) begin : g_slot
    logic [2:0] w;
    assign w = {1'b0, off} + 3'(k);
    assign inst[32*k +: 32] = w[2] ? ZEROWORD : line[32*w[1:0] +: 32];
  end
  assign cnt = 3'd4 - {1'b0, off};
endmodule

// File: rtl/ifu_line_cache.sv
// ifu_line_cache: direct-mapped 16-byte-line instruction cache, two-beat refill.
// ICACHE_FENCEI_EN adds flush_i to invalidate all lines.
module ifu_line_cache
  import ifu_line_cache_pkg::*;
#(
  parameter int LINES  = 16,
  parameter int ADDR_W = PCBUS
) (
  input  logic              clk,
  input  logic              rst,
`ifdef ICACHE_FENCEI_EN
  input  logic              flush_i,
`endif
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  output logic [127:0]      inst_o,
  output logic [2:0]        inst_cnt_o,
  output logic              cache_un_ready_o,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [63:0]       mem_rdata_i
);
  localparam int IDX_W = $clog2(LINES);
  localparam int LA_W  = ADDR_W - LINE_OFF_W;
  localparam int TAG_W = LA_W - IDX_W;
  logic [127:0]     data_q [LINES];
  logic [TAG_W-1:0] tag_q  [LINES];
  logic [LINES-1:0] valid_q;
  state_t           state_q;
  logic [LA_W-1:0]  line_q;
  logic [63:0]      beat0_q, beat1_q;
  logic [IDX_W-1:0] idx, fill_idx;
  logic [TAG_W-1:0] tag, fill_tag;
  logic [127:0]     aligned;
  logic [2:0]       cnt;
  logic             idle, fill, hit, miss, flush_idle, flush_fill, unused_pc;
  assign idx       = pc_i[IDX_W+LINE_OFF_W-1:LINE_OFF_W];
  assign tag       = pc_i[ADDR_W-1:IDX_W+LINE_OFF_W];
  assign fill_idx  = line_q[IDX_W-1:0];
  assign fill_tag  = line_q[LA_W-1:IDX_W];
  assign unused_pc = ^pc_i[1:0];
  assign idle      = state_q == S_IDLE;
  assign fill      = state_q == S_FILL;
`ifdef ICACHE_FENCEI_EN
  logic flush_pend_q;
  assign flush_idle = flush_i & idle;
  assign flush_fill = flush_pend_q | flush_i;
  always_ff @(posedge clk)
    flush_pend_q <= (rst | fill) ? 1'b0 : flush_pend_q | (flush_i & ~idle);
`else
  assign flush_idle = 1'b0;
  assign flush_fill = 1'b0;
`endif
  assign hit  = pc_valid_i & idle & ~flush_idle & valid_q[idx] & (tag_q[idx] == tag);
  assign miss = pc_valid_i & idle & ~flush_idle & ~hit;
  ifu_line_align u_align (
    .line(data_q[idx]),
    .off (pc_i[3:2]),
    .inst(aligned),
    .cnt (cnt)
  );
  // Array contents are never reset; hit gating keeps X off the outputs.
  assign inst_o           = hit ? aligned : '0;
  assign inst_cnt_o       = hit ? cnt : 3'd0;
  assign cache_un_ready_o = ~idle | flush_idle | miss;
  assign mem_addr_o       = {line_q, {LINE_OFF_W{1'b0}}};
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      mem_req_o <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (miss) begin
          line_q    <= pc_i[ADDR_W-1:LINE_OFF_W];
          mem_req_o <= 1'b1;
          state_q   <= S_REQ;
        end
        S_REQ: if (mem_gnt_i) begin
          mem_req_o <= 1'b0;
          state_q   <= S_BEAT0;
        end
        S_BEAT0: if (mem_rvalid_i) begin
          beat0_q <= mem_rdata_i;
          state_q <= S_BEAT1;
        end
        S_BEAT1: if (mem_rvalid_i) begin
          beat1_q <= mem_rdata_i;
          state_q <= S_FILL;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end
  always_ff @(posedge clk)
    if (fill) begin
      data_q[fill_idx] <= {beat1_q, beat0_q};
      tag_q[fill_idx]  <= fill_tag;
    end
  // A flush seen during refill also kills the line just written.
  always_ff @(posedge clk)
    if (rst | flush_idle | (fill & flush_fill)) valid_q <= '0;
    else if (fill) valid_q[fill_idx] <= 1'b1;
endmodule

// File: tb/tb_ifu_line_cache.sv
// tb_ifu_line_cache: directed scoreboard bench for ifu_line_cache
module tb_ifu_line_cache;
  logic         clk = 1'b0, rst = 1'b1, pc_valid_i = 1'b0;
  logic         mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0, flush_i = 1'b0;
  logic [63:0]  pc_i = '0, mem_rdata_i = '0, mem_addr_o;
  logic [127:0] inst_o;
  logic [2:0]   inst_cnt_o;
  logic         cache_un_ready_o, mem_req_o;
  int           checks = 0, errors = 0;
  logic [130:0] exp_q [$];
  logic [130:0] e;
  localparam logic [127:0] L0 = 128'h00300193_00200113_00000013_00100093;
  localparam logic [127:0] L1 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] L2 = 128'hBBBB0003_BBBB0002_BBBB0001_BBBB0000;
  localparam logic [127:0] L4 = 128'hCCCC0003_CCCC0002_CCCC0001_CCCC0000;
  ifu_line_cache dut (
    .clk(clk),
    .rst(rst),
`ifdef ICACHE_FENCEI_EN
    .flush_i(flush_i),
`endif
    .pc_valid_i(pc_valid_i),
    .pc_i(pc_i),
    .inst_o(inst_o),
    .inst_cnt_o(inst_cnt_o),
    .cache_un_ready_o(cache_un_ready_o),
    .mem_req_o(mem_req_o),
    .mem_addr_o(mem_addr_o),
    .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] beat(input logic [63:0] a);
    case (a)
      64'h80000000: return 64'h00000013_00100093;
      64'h80000008: return 64'h00300193_00200113;
      64'h80000010: return 64'hAAAA0001_AAAA0000;
      64'h80000018: return 64'hAAAA0003_AAAA0002;
      64'h80000020: return 64'hBBBB0001_BBBB0000;
      64'h80000028: return 64'hBBBB0003_BBBB0002;
      64'h80000100: return 64'hCCCC0001_CCCC0000;
      64'h80000108: return 64'hCCCC0003_CCCC0002;
      default:      return 64'hDEADBEEF_DEADBEEF;
    endcase
  endfunction
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic fetch(input logic [63:0] pc, input logic [127:0] ei, input logic [2:0] ec, input bit em);
    int n = 0;
    exp_q.push_back({ei, ec});
    pc_i = pc;
    pc_valid_i = 1'b1;
    @(negedge clk);
    while (cache_un_ready_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check("fetch_done", cache_un_ready_o, 0);
    check("miss_seen", n > 0, em);
    @(posedge clk);
    #1 pc_valid_i = 1'b0;
  endtask
  task automatic serve(input logic [63:0] a, input int gw, input int gap);
    int n = 0;
    while (!mem_req_o && n < 50) begin
      n++;
      tick;
    end
    check("req_seen", mem_req_o, 1);
    repeat (gw) begin
      check("addr_hold", mem_addr_o, a);
      check("req_hold", mem_req_o, 1);
      check("unready_hold", cache_un_ready_o, 1);
      tick;
    end
    check("mem_addr", mem_addr_o, a);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0;
    check("req_drop", mem_req_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = beat(a);
    tick;
    mem_rvalid_i = 1'b0;
    repeat (gap) begin
      check("unready_gap", cache_un_ready_o, 1);
      tick;
    end
    mem_rvalid_i = 1'b1;
    mem_rdata_i = beat(a + 64'd8);
    tick;
    mem_rvalid_i = 1'b0;
    mem_rdata_i = '0;
  endtask
  always @(negedge clk)
    if (!rst && pc_valid_i && !cache_un_ready_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output inst=%h cnt=%0d", inst_o, inst_cnt_o);
      end else begin
        e = exp_q.pop_front();
        check("inst", inst_o, e[130:3]);
        check("cnt", inst_cnt_o, e[2:0]);
      end
    end
  initial begin
    #2000000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end
  initial begin
    int n;
    repeat (3) tick;
    rst = 1'b0;
    check("rst_inst", inst_o, 0);
    check("rst_cnt", inst_cnt_o, 0);
    check("rst_unready", cache_un_ready_o, 0);
    check("rst_req", mem_req_o, 0);
    fork
      fetch(64'h80000000, L0, 3'd4, 1'b1);
      serve(64'h80000000, 0, 0);
    join
    fetch(64'h80000008, 128'h00300193_00200113, 3'd2, 1'b0);
    fetch(64'h8000000C, 128'h00300193, 3'd1, 1'b0);
    fetch(64'h80000004, 128'h00000000_00300193_00200113_00000013, 3'd3, 1'b0);
    fork
      fetch(64'h80000100, L4, 3'd4, 1'b1);
      serve(64'h80000100, 0, 0);
    join
    fork
      fetch(64'h80000000, L0, 3'd4, 1'b1);
      serve(64'h80000000, 0, 0);
    join
    fork
      fetch(64'h80000014, 128'h00000000_AAAA0003_AAAA0002_AAAA0001, 3'd3, 1'b1);
      serve(64'h80000010, 5, 3);
    join
    fetch(64'h80000010, L1, 3'd4, 1'b0);
    pc_i = 64'h80000020;
    pc_valid_i = 1'b1;
    n = 0;
    while (!mem_req_o && n < 50) begin
      n++;
      tick;
    end
    check("rr_req_seen", mem_req_o, 1);
    mem_gnt_i = 1'b1;
    tick;
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b1;
    mem_rdata_i = beat(64'h80000020);
    tick;
    mem_rvalid_i = 1'b0;
    rst = 1'b1;
    pc_valid_i = 1'b0;
    tick;
    rst = 1'b0;
    check("rr_req", mem_req_o, 0);
    check("rr_unready", cache_un_ready_o, 0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i = 64'hFFFFFFFF_FFFFFFFF;
    tick;
    mem_rvalid_i = 1'b0;
    tick;
    fork
      fetch(64'h80000020, L2, 3'd4, 1'b1);
      serve(64'h80000020, 0, 0);
    join
    fork
      fetch(64'h80000000, L0, 3'd4, 1'b1);
      serve(64'h80000000, 0, 0);
    join
`ifdef ICACHE_FENCEI_EN
    fetch(64'h80000020, L2, 3'd4, 1'b0);
    flush_i = 1'b1;
    check("flush_unready", cache_un_ready_o, 1);
    tick;
    flush_i = 1'b0;
    fork
      fetch(64'h80000020, L2, 3'd4, 1'b1);
      serve(64'h80000020, 0, 0);
    join
    fork
      fetch(64'h80000010, L1, 3'd4, 1'b1);
      begin
        serve(64'h80000010, 0, 0);
        serve(64'h80000010, 0, 0);
      end
      begin
        tick;
        tick;
        flush_i = 1'b1;
        tick;
        flush_i = 1'b0;
      end
    join
`endif
    tick;
    tick;
    check("queue_empty", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
